// File: rtl/wb_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM state encoding,
// requester index type and the timeout counter width.
package wb_pkg;

    // Arbiter FSM: IDLE waits for a strobe, BUSY owns the peripheral port.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Index of a requester (0 = m0, 1 = m1).
    typedef logic req_idx_t;

    localparam req_idx_t REQ_M0 = 1'b0;
    localparam req_idx_t REQ_M1 = 1'b1;

    // Width of the per-transfer timeout counter.
    localparam int CNT_W = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin choice between two strobes. A lone strobe always wins; on a tie
// the requester that was not served last wins.
module arb_rr_pick
    import wb_pkg::*;
(
    input  logic     stb0_i,
    input  logic     stb1_i,
    input  req_idx_t last_q_i,
    output req_idx_t grant_o,
    output logic     valid_o
);

    // Pick the winner purely combinationally; the top registers it.
    always_comb begin
        valid_o = stb0_i | stb1_i;
        if (stb0_i && stb1_i) begin
            grant_o = (last_q_i == REQ_M0) ? REQ_M1 : REQ_M0;
        end else if (stb1_i) begin
            grant_o = REQ_M1;
        end else begin
            grant_o = REQ_M0;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter with registered round-robin grant,
// combinational return path and a per-transfer timeout that fakes an ack.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    // requester 0
    input  logic       m0_we_i,
    input  logic [3:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    input  logic       m0_stb_i,
    output logic [7:0] m0_dat_o,
    output logic       m0_ack_o,
    // requester 1
    input  logic       m1_we_i,
    input  logic [3:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    input  logic       m1_stb_i,
    output logic [7:0] m1_dat_o,
    output logic       m1_ack_o,
    // peripheral
    output logic       wb_we_o,
    output logic [3:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    output logic       wb_stb_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,
    // sticky timeout flag
    output logic       timeout_o
);

    // Counter value seen in the last BUSY cycle before the transfer is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    req_idx_t         grant_q;
    req_idx_t         last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    req_idx_t pick;
    logic     pick_valid;

    logic       busy;
    logic       g_stb;
    logic       g_we;
    logic [3:0] g_adr;
    logic [7:0] g_dat;
    logic       to_fire;
    logic       done;
    logic       abandon;
    logic       g_ack;
    logic [7:0] g_rdat;

    arb_rr_pick u_pick (
        .stb0_i   (m0_stb_i),
        .stb1_i   (m1_stb_i),
        .last_q_i (last_q),
        .grant_o  (pick),
        .valid_o  (pick_valid)
    );

    // Select the granted requester's request lines and decide how BUSY ends.
    always_comb begin
        busy    = (state_q == BUSY);
        g_stb   = (grant_q == REQ_M1) ? m1_stb_i : m0_stb_i;
        g_we    = (grant_q == REQ_M1) ? m1_we_i  : m0_we_i;
        g_adr   = (grant_q == REQ_M1) ? m1_adr_i : m0_adr_i;
        g_dat   = (grant_q == REQ_M1) ? m1_dat_i : m0_dat_i;
        // A timeout only counts while the requester still wants the bus;
        // a dropped strobe is an abandon, and a real ack always takes priority.
        to_fire = busy && g_stb && !wb_ack_i && (cnt_q == CNT_LAST);
        done    = busy && (wb_ack_i || to_fire);
        abandon = busy && !g_stb && !wb_ack_i;
        g_ack   = done;
        g_rdat  = (busy && !to_fire) ? wb_dat_i : 8'h00;
    end

    // Drive the peripheral and requester ports; everything idles at zero.
    always_comb begin
        wb_stb_o  = busy && g_stb && !to_fire;
        wb_we_o   = busy && g_we;
        wb_adr_o  = busy ? g_adr : 4'h0;
        wb_dat_o  = busy ? g_dat : 8'h00;
        m0_ack_o  = (grant_q == REQ_M0) && g_ack;
        m1_ack_o  = (grant_q == REQ_M1) && g_ack;
        m0_dat_o  = (grant_q == REQ_M0) ? g_rdat : 8'h00;
        m1_dat_o  = (grant_q == REQ_M1) ? g_rdat : 8'h00;
        timeout_o = timeout_q;
    end

    // FSM, grant, round-robin history, timeout counter and sticky flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= REQ_M0;
            last_q    <= REQ_M1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= BUSY;
                        grant_q <= pick;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_q <= IDLE;
                        last_q  <= grant_q;
                        if (to_fire) begin
                            timeout_q <= 1'b1;
                        end
                    end else if (abandon) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
